accum_ovf_frame: RTL and testbench

//  Framed signed accumulator with overflow detection: sums (or subtracts) N_SAMPLES signed

---
 rtl/accum_pkg.sv | 15 +
 rtl/sat_addsub.sv | 36 +++
 rtl/accum_ovf_frame.sv | 126 ++++++++++++
 tb/tb_accum_ovf_frame.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and saturation limits for the framed accumulator.
package accum_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  // Limits are returned 64 bits wide; callers keep the low nb bits.
  function automatic logic [63:0] acc_max(input int unsigned nb);
    return (64'd1 << (nb - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int unsigned nb);
    return 64'd1 << (nb - 1);
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational signed add/subtract with overflow detect.
// Clamps to the signed range when ACCUM_SAT_EN is defined, otherwise wraps.
module sat_addsub
  import accum_pkg::*;
#(
  parameter int unsigned NB = 16
) (
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  input  logic          mode,
  output logic [NB-1:0] res,
  output logic          ovf
);

`ifdef ACCUM_SAT_EN
  localparam logic [63:0]   MAX64 = acc_max(NB);
  localparam logic [63:0]   MIN64 = acc_min(NB);
  localparam logic [NB-1:0] MAX   = MAX64[NB-1:0];
  localparam logic [NB-1:0] MIN   = MIN64[NB-1:0];
`endif

  logic [NB-1:0] raw;

  always_comb begin
    raw = mode ? (a - b) : (a + b);
    // Subtraction overflows when operand signs differ, addition when they match.
    ovf = (mode ? (a[NB-1] != b[NB-1]) : (a[NB-1] == b[NB-1])) && (raw[NB-1] != a[NB-1]);
    res = raw;
`ifdef ACCUM_SAT_EN
    if (ovf) begin
      res = a[NB-1] ? MIN : MAX;
    end
`endif
  end

endmodule

// File: rtl/accum_ovf_frame.sv
// Framed signed accumulator: N_SAMPLES accepted samples produce one result with
// per-frame and sticky overflow flags. Saturation is enabled by defining ACCUM_SAT_EN.
module accum_ovf_frame
  import accum_pkg::*;
#(
  parameter int unsigned NB_DATA   = 16,
  parameter int unsigned NB_ACC    = 16,
  parameter int unsigned N_SAMPLES = 8,
  localparam int unsigned NB_COUNT = $clog2(N_SAMPLES)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_mode,
  input  logic                i_clear,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_ACC-1:0]   o_data,
  output logic                o_overflow,
  output logic                o_ovf_sticky,
  output logic [NB_COUNT-1:0] o_count
);

  localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(N_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [NB_ACC-1:0]   acc_q, acc_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                frame_ovf_q, frame_ovf_d;
  logic [NB_ACC-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                sticky_q, sticky_d;

  logic [NB_ACC-1:0]   x_ext;
  logic [NB_ACC-1:0]   step_res;
  logic                step_ovf;

  assign x_ext = NB_ACC'($signed(i_data));

  sat_addsub #(
    .NB (NB_ACC)
  ) u_sat_addsub (
    .a    (acc_q),
    .b    (x_ext),
    .mode (i_mode),
    .res  (step_res),
    .ovf  (step_ovf)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      frame_ovf_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      frame_ovf_q <= frame_ovf_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    frame_ovf_d = frame_ovf_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;

    // Clear behaves like reset and also discards any same-cycle accept.
    if (i_clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      count_d     = '0;
      frame_ovf_d = 1'b0;
      data_d      = '0;
      ovf_d       = 1'b0;
      sticky_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (i_valid) begin
            sticky_d = sticky_q | step_ovf;
            if (count_q == LAST) begin
              data_d      = step_res;
              ovf_d       = frame_ovf_q | step_ovf;
              acc_d       = '0;
              count_d     = '0;
              frame_ovf_d = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d       = step_res;
              count_d     = count_q + 1'b1;
              frame_ovf_d = frame_ovf_q | step_ovf;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign o_ready      = (state_q == ACCUM);
  assign o_valid      = (state_q == HOLD);
  assign o_data       = data_q;
  assign o_overflow   = ovf_q;
  assign o_ovf_sticky = sticky_q;
  assign o_count      = count_q;

endmodule

// File: tb/tb_accum_ovf_frame.sv
// Scoreboard bench for accum_ovf_frame: directed frames, reset/clear, then random traffic.
// Expected results come from an integer-arithmetic model; ACCUM_SAT_EN selects clamping.
module tb_accum_ovf_frame;

  localparam int NS   = 4;
  localparam int HALF = 32768;
  localparam int FULL = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mode, i_clear, i_ready;
  logic [15:0] i_data;
  logic        o_ready, o_valid, o_overflow, o_ovf_sticky;
  logic [15:0] o_data;
  logic [1:0]  o_count;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_acc, m_cnt;
  bit m_fovf, m_sticky, m_hold;
  // Values the monitor expects after the most recent edge
  int exp_cnt    = 0;
  bit exp_sticky = 1'b0;
  bit exp_hold   = 1'b0;
  bit have_prev  = 1'b0;
  int prev_data  = 0;

  accum_ovf_frame #(
    .NB_DATA   (16),
    .NB_ACC    (16),
    .N_SAMPLES (NS)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_mode       (i_mode),
    .i_clear      (i_clear),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_overflow   (o_overflow),
    .o_ovf_sticky (o_ovf_sticky),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One signed step computed on unbounded integers, then wrapped or clamped.
  task automatic step(input int acc, input int x, input bit mode, output int res, output bit ovf);
    int t;
    t   = mode ? acc - x : acc + x;
    ovf = (t >= HALF) || (t < -HALF);
`ifdef ACCUM_SAT_EN
    res = !ovf ? t : (t > 0 ? HALF - 1 : -HALF);
`else
    res = t;
    if (t >= HALF) res = t - FULL;
    if (t < -HALF) res = t + FULL;
`endif
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_fovf = 0; m_sticky = 0; m_hold = 0;
    sbq.delete();
  endtask

  // Drive one cycle of inputs, advance the model, and return 1 time unit after the edge.
  task automatic drive_cycle(input bit v, input int d, input bit m, input bit r, input bit c);
    int res;
    bit ov;
    logic [31:0] dv;
    dv      = d;
    i_valid = v;
    i_data  = dv[15:0];
    i_mode  = m;
    i_ready = r;
    i_clear = c;
    #3;
    if (c) begin
      model_reset();
    end else if (m_hold) begin
      if (r) m_hold = 0;
    end else if (v) begin
      step(m_acc, d, m, res, ov);
      m_sticky |= ov;
      if (m_cnt == NS - 1) begin
        sbq.push_back('{data: res, ovf: m_fovf | ov});
        m_acc = 0; m_cnt = 0; m_fovf = 0; m_hold = 1;
      end else begin
        m_acc = res; m_cnt++; m_fovf |= ov;
      end
    end
    @(posedge clk);
    #1;
    exp_cnt    = m_cnt;
    exp_sticky = m_sticky;
    exp_hold   = m_hold;
  endtask

  task automatic frame(input int a, input int b, input int c, input int d, input bit m);
    drive_cycle(1, a, m, 1, 0);
    drive_cycle(1, b, m, 1, 0);
    drive_cycle(1, c, m, 1, 0);
    drive_cycle(1, d, m, 1, 0);
  endtask

  // Monitor: per-cycle handshake/state checks and scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("o_valid", int'(o_valid), int'(exp_hold));
      check("o_ready", int'(o_ready), int'(!exp_hold));
      check("o_count", int'(o_count), exp_cnt);
      check("o_ovf_sticky", int'(o_ovf_sticky), int'(exp_sticky));
      if (have_prev && o_valid) check("hold_stable", int'($signed(o_data)), prev_data);
      have_prev = o_valid && !i_ready;
      prev_data = int'($signed(o_data));
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("o_data", int'($signed(o_data)), e.data);
          check("o_overflow", int'(o_overflow), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    logic [15:0] r16;
    int d;
    bit v, r, c, m;
    rst = 1'b1; i_valid = 0; i_data = '0; i_mode = 0; i_clear = 0; i_ready = 1;
    model_reset();
    #3;
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_count", int'(o_count), 0);
    check("rst_sticky", int'(o_ovf_sticky), 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", int'(o_ready), 1);

    // 1: plain sum
    frame(1, 2, 3, 4, 0);
    check("t1_valid", int'(o_valid), 1);
    check("t1_data", int'($signed(o_data)), 10);
    check("t1_ovf", int'(o_overflow), 0);
    check("t1_count", int'(o_count), 0);
    drive_cycle(0, 0, 0, 1, 0);

    // 2: positive overflow
    frame(32767, 1, 0, 0, 0);
`ifdef ACCUM_SAT_EN
    check("t2_data", int'($signed(o_data)), 32767);
`else
    check("t2_data", int'($signed(o_data)), -32768);
`endif
    check("t2_ovf", int'(o_overflow), 1);
    check("t2_sticky", int'(o_ovf_sticky), 1);
    drive_cycle(0, 0, 0, 1, 0);

    // 3: most-negative then subtract
    drive_cycle(1, -32768, 0, 1, 0);
    drive_cycle(1, 1, 1, 1, 0);
    drive_cycle(1, 0, 1, 1, 0);
    drive_cycle(1, 0, 1, 1, 0);
`ifdef ACCUM_SAT_EN
    check("t3_data", int'($signed(o_data)), -32768);
`else
    check("t3_data", int'($signed(o_data)), 32767);
`endif
    check("t3_ovf", int'(o_overflow), 1);
    drive_cycle(0, 0, 0, 1, 0);

    // 4: backpressure with i_valid held high
    frame(1, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 99, 0, 0, 0);
      check("t4_ready_low", int'(o_ready), 0);
      check("t4_data_held", int'($signed(o_data)), 4);
    end
    drive_cycle(0, 0, 0, 1, 0);
    check("t4_released", int'(o_valid), 0);

    // 5: async reset mid-frame, clear in HOLD, clean frame after
    drive_cycle(1, 7, 0, 1, 0);
    drive_cycle(1, 8, 0, 1, 0);
    i_valid = 0;
    #1;
    rst = 1'b1;
    model_reset();
    exp_cnt = 0; exp_sticky = 0; exp_hold = 0;
    #1;
    check("t5_rst_count", int'(o_count), 0);
    check("t5_rst_valid", int'(o_valid), 0);
    check("t5_rst_data", int'(o_data), 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    frame(32767, 32767, 0, 0, 0);
    check("t5_sticky_set", int'(o_ovf_sticky), 1);
    drive_cycle(0, 0, 0, 0, 1);
    check("t5_clr_valid", int'(o_valid), 0);
    check("t5_clr_sticky", int'(o_ovf_sticky), 0);
    frame(5, 5, 5, 5, 0);
    check("t5_data", int'($signed(o_data)), 20);
    drive_cycle(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      r16 = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = 32767;
        1: d = -32768;
        2: d = int'($urandom_range(0, 20)) - 10;
        default: d = int'($signed(r16));
      endcase
      v = ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 63) == 0);
      r = c ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive_cycle(v, d, m, r, c);
    end

    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 1, 0);
    check("drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
